// File: rtl/psuedo_fifo_ram_pkg.sv
// Shared sizing defaults for the pseudo-FIFO and its backing RAM.
package psuedo_fifo_ram_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  localparam int DEF_DEPTH = depth_of(DEF_ADDR_WIDTH);

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, shared clock.
module fifo_sdp_ram
  import psuedo_fifo_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // No reset on the read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/psuedo_fifo_ram.sv
// FIFO built on a simple dual-port RAM: pointers, occupancy count, flags, read valid.
module psuedo_fifo_ram
  import psuedo_fifo_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_en,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  valid
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  loaded;
  logic [DATA_WIDTH-1:0] ram_q;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign wr_accept = write_en && !full;
  assign rd_accept = read_en && !empty;

  fifo_sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_accept),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd_en  (rd_accept),
    .rd_addr(rd_ptr),
    .rd_data(ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      loaded <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        loaded <= 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      valid <= rd_accept;
    end
  end

  // The RAM read register has no reset; 'loaded' masks it to zero until the
  // first read after reset, giving an asynchronously cleared data_out.
  assign data_out = loaded ? ram_q : '0;

endmodule

// File: tb/tb_psuedo_fifo_ram.sv
// Directed bench for psuedo_fifo_ram: vector table plus fill, wrap and reset sequences.
module tb_psuedo_fifo_ram;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          write_en;
  logic          read_en;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          valid;

  always #5 clk = ~clk;

  psuedo_fifo_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .write_en(write_en),
    .read_en (read_en),
    .data_out(data_out),
    .full    (full),
    .empty   (empty),
    .valid   (valid)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          v;
    logic          e;
    logic          f;
  } vec_t;

  vec_t vecs[12];
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge; returns at the following negedge.
  task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d);
    write_en = wr;
    read_en  = rd;
    data_in  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 16'd0,     16'd0,     1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'd42069, 16'd0,     1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'd0,     16'd42069, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 16'd0,     16'd42069, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'd65535, 16'd42069, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 16'd4444,  16'd42069, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'd0,     16'd65535, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'd0,     16'd4444,  1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'd0,     16'd4444,  1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 16'd7,     16'd4444,  1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 16'd8,     16'd7,     1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 16'd0,     16'd8,     1'b1, 1'b1, 1'b0};

    rst_n    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;
    #12;
    chk("rst_dout",  32'(data_out), 32'd0);
    chk("rst_valid", 32'(valid),    32'd0);
    chk("rst_empty", 32'(empty),    32'd1);
    chk("rst_full",  32'(full),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk($sformatf("vec%0d_dout", i),  32'(data_out), 32'(vecs[i].dout));
      chk($sformatf("vec%0d_valid", i), 32'(valid),    32'(vecs[i].v));
      chk($sformatf("vec%0d_empty", i), 32'(empty),    32'(vecs[i].e));
      chk($sformatf("vec%0d_full", i),  32'(full),     32'(vecs[i].f));
    end

    // Fill to 256, drop extra writes, then drain in order.
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 1'b0, 16'(i));
      if (i == 254) chk("fill255_full", 32'(full), 32'd0);
    end
    chk("fill256_full",  32'(full),  32'd1);
    chk("fill256_empty", 32'(empty), 32'd0);
    cycle(1'b1, 1'b0, 16'd999);
    chk("drop257_full", 32'(full), 32'd1);
    cycle(1'b1, 1'b1, 16'd1234);
    chk("fullrw_dout",  32'(data_out), 32'd0);
    chk("fullrw_valid", 32'(valid),    32'd1);
    chk("fullrw_full",  32'(full),     32'd0);
    for (int i = 1; i < 256; i++) begin
      cycle(1'b0, 1'b1, 16'd0);
      chk($sformatf("drain%0d_dout", i), 32'(data_out), 32'(i));
      chk($sformatf("drain%0d_valid", i), 32'(valid), 32'd1);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    cycle(1'b0, 1'b1, 16'd0);
    chk("empty_rd_valid", 32'(valid),    32'd0);
    chk("empty_rd_dout",  32'(data_out), 32'd255);

    // Fill to 250, drain to 5, then stream read+write across the pointer wrap.
    for (int i = 0; i < 250; i++) begin
      cycle(1'b1, 1'b0, 16'(1000 + i));
      q.push_back(16'(1000 + i));
    end
    for (int i = 0; i < 245; i++) begin
      cycle(1'b0, 1'b1, 16'd0);
      exp_word = q.pop_front();
      chk($sformatf("pre%0d_dout", i), 32'(data_out), 32'(exp_word));
    end
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b1, 16'(2000 + k));
      exp_word = q.pop_front();
      q.push_back(16'(2000 + k));
      chk($sformatf("rw%0d_dout", k),  32'(data_out), 32'(exp_word));
      chk($sformatf("rw%0d_valid", k), 32'(valid),    32'd1);
      chk($sformatf("rw%0d_empty", k), 32'(empty),    32'd0);
      chk($sformatf("rw%0d_full", k),  32'(full),     32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 16'd0);
      exp_word = q.pop_front();
      chk($sformatf("wrap%0d_dout", i), 32'(data_out), 32'(exp_word));
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // Reset with 9 words left and valid high must clear outputs immediately.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 16'(300 + i));
    cycle(1'b0, 1'b1, 16'd0);
    chk("prerst_dout",  32'(data_out), 32'd300);
    chk("prerst_valid", 32'(valid),    32'd1);
    write_en = 1'b0;
    read_en  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_empty", 32'(empty),    32'd1);
    chk("midrst_full",  32'(full),     32'd0);
    chk("midrst_valid", 32'(valid),    32'd0);
    chk("midrst_dout",  32'(data_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 16'd77);
    chk("postrst_wr_empty", 32'(empty), 32'd0);
    cycle(1'b0, 1'b1, 16'd0);
    chk("postrst_dout",  32'(data_out), 32'd77);
    chk("postrst_valid", 32'(valid),    32'd1);
    chk("postrst_empty", 32'(empty),    32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
